// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   lsu_size_e  - request size codes (byte/half/word, 2'b00 is illegal)
//   lsu_state_e - FSM state encoding
//   last_idx()  - index of the final byte of an access (N-1)
//   misaligned()- natural-alignment test, used by the LSU_ALIGN_CHECK_EN build
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_ILL  = 2'b00,
    SIZE_BYTE = 2'b01,
    SIZE_HALF = 2'b10,
    SIZE_WORD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_WORD: last_idx = 2'd3;
      SIZE_HALF: last_idx = 2'd1;
      default:   last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      SIZE_HALF: misaligned = addr_lo[0];
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extension of the right-justified load accumulator.
// Ports:
//   acc_i      [31:0] bytes collected by the load, last byte in [7:0]
//   size_i     [1:0]  access size code (lsu_size_e)
//   unsigned_i        1 = zero-extend, 0 = sign-extend
//   result_o   [31:0] extended load result (0 for the illegal size code)
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (size_i)
      SIZE_WORD: result_o = acc_i;
      SIZE_HALF: result_o = {{16{~unsigned_i & acc_i[15]}}, acc_i[15:0]};
      SIZE_BYTE: result_o = {{24{~unsigned_i & acc_i[7]}}, acc_i[7:0]};
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: serialises 8/16/32-bit CPU loads and stores onto a
// byte-wide memory port, big-endian (most significant byte at the lowest
// address), one byte per cycle.
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o  request handshake, ready only while idle
//   req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//   resp_valid_o (1-cycle pulse), resp_rdata_o, resp_err_o
//   mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, mem_rdata_i (combinational read)
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with an error response instead of performing them byte-serially.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [7:0]  mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        write_q, unsigned_q, err_q;
  logic        accept, reject;
  logic [1:0]  byte_sel;
  logic [31:0] ext_data;

  assign accept = req_valid_i && (state_q == ST_IDLE);

`ifdef LSU_ALIGN_CHECK_EN
  assign reject = (req_size_i == SIZE_ILL) || misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign reject = (req_size_i == SIZE_ILL);
`endif

  // Byte k of N comes from bits [8*(N-1-k) +: 8] of the store data.
  assign byte_sel = last_idx(size_q) - cnt_q;

  lsu_extend u_extend (
    .acc_i      (acc_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .result_o   (ext_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        size_q     <= req_size_i;
        write_q    <= req_write_i;
        unsigned_q <= req_unsigned_i;
        err_q      <= reject;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = reject ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_addr_o = addr_q + {30'd0, cnt_q};
        mem_we_o   = write_q;
        mem_re_o   = ~write_q;
        if (write_q) begin
          mem_wdata_o = wdata_q[{byte_sel, 3'b000} +: 8];
        end else begin
          acc_d = {acc_q[23:0], mem_rdata_i};
        end
        if (cnt_q == last_idx(size_q)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        if (!err_q && !write_q) begin
          resp_rdata_o = ext_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [7:0]  mem_rdata_i;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_write_i    (req_write_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_we_o       (mem_we_o),
    .mem_re_o       (mem_re_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Read-only contents presented on mem_rdata_i.
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h02: rom = 8'hDE;  8'h03: rom = 8'hAD;  8'h04: rom = 8'hBE;  8'h05: rom = 8'hEF;
      8'h20: rom = 8'h80;  8'h21: rom = 8'h01;
      8'h30: rom = 8'hF0;
      8'h50: rom = 8'h11;  8'h51: rom = 8'h22;  8'h52: rom = 8'h33;  8'h53: rom = 8'h44;
      8'h60: rom = 8'h7F;  8'h61: rom = 8'hFE;
      default: rom = 8'h00;
    endcase
  endfunction

  assign mem_rdata_i = rom(mem_addr_o[7:0]);

  logic [7:0] wmem [0:255] = '{default: 8'h00};
  int unsigned cyc = 0;
  int unsigned wr_cnt = 0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i && mem_we_o) begin
      wmem[mem_addr_o[7:0]] <= mem_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc_cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  resp_t       exp_resp[$];
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none_or_in_time", name);
  endtask

  task automatic run_monitor();
    wr_t   w;
    resp_t r;
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (mem_we_o && mem_re_o) fail_now("both_strobes");
        if (mem_we_o) begin
          if (exp_wr.size() == 0) fail_now("unexpected_write");
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr_o, w.addr);
            chk("wr_data", {24'd0, mem_wdata_o}, {24'd0, w.data});
          end
        end
        if (mem_re_o) begin
          if (exp_rd.size() == 0) fail_now("unexpected_read");
          else begin
            a = exp_rd.pop_front();
            chk("rd_addr", mem_addr_o, a);
          end
        end
        if (resp_valid_o) begin
          if (exp_resp.size() == 0) fail_now("unexpected_resp");
          else begin
            r = exp_resp.pop_front();
            chk("resp_rdata", resp_rdata_o, r.rdata);
            chk("resp_err", {31'd0, resp_err_o}, {31'd0, r.err});
            chk("resp_latency", cyc - r.acc_cyc + 1, r.lat);
          end
        end
      end
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    exp_wr.push_back('{a, d});
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((exp_resp.size() != 0 || !req_ready_o) && g < 40) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 40) fail_now(name);
  endtask

  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int unsigned lat);
    int g = 0;
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_write_i    = wr;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    while (!req_ready_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 20) fail_now({name, "_accept_timeout"});
    exp_resp.push_back('{exp_rdata, exp_err, lat, cyc + 1});
    @(negedge clk_i);
    // Scramble the request lines while busy; the latched copy must be used.
    req_valid_i    = 1'b0;
    req_write_i    = ~wr;
    req_size_i     = 2'b00;
    req_unsigned_i = ~uns;
    req_addr_i     = 32'hFFFF_FF00;
    req_wdata_i    = 32'hA5A5_5A5A;
    wait_idle({name, "_resp_timeout"});
  endtask

  task automatic run_stim();
    int unsigned base;
    int g;
    rst_i = 1'b0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_strobes", {30'd0, mem_we_o, mem_re_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);

    // Word store, big-endian bytes
    push_wr(32'h10, 8'h12); push_wr(32'h11, 8'h34); push_wr(32'h12, 8'h56); push_wr(32'h13, 8'h78);
    issue("st_word", 1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 5);

    // Half loads 0x80,0x01
    exp_rd.push_back(32'h20); exp_rd.push_back(32'h21);
    issue("ld_half_s", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hFFFF_8001, 1'b0, 3);
    exp_rd.push_back(32'h20); exp_rd.push_back(32'h21);
    issue("ld_half_u", 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h0000_8001, 1'b0, 3);

    // Byte loads of 0xF0
    exp_rd.push_back(32'h30);
    issue("ld_byte_u", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h0000_00F0, 1'b0, 2);
    exp_rd.push_back(32'h30);
    issue("ld_byte_s", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFF_FFF0, 1'b0, 2);

    // Word load and positive signed half
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h50 + i);
    issue("ld_word", 1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 32'h1122_3344, 1'b0, 5);
    exp_rd.push_back(32'h60); exp_rd.push_back(32'h61);
    issue("ld_half_pos", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h0000_7FFE, 1'b0, 3);

    // Half and byte stores use only the low bits of wdata
    push_wr(32'h70, 8'hBE); push_wr(32'h71, 8'hEF);
    issue("st_half", 1'b1, 2'b10, 1'b0, 32'h70, 32'hCAFE_BEEF, 32'h0, 1'b0, 3);
    push_wr(32'h72, 8'hA5);
    issue("st_byte", 1'b1, 2'b01, 1'b0, 32'h72, 32'h1234_56A5, 32'h0, 1'b0, 2);

    // Illegal size code
    issue("ill_load", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    issue("ill_store", 1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);

`ifdef LSU_ALIGN_CHECK_EN
    issue("mis_ld_word", 1'b0, 2'b11, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 1);
    issue("mis_st_half", 1'b1, 2'b10, 1'b0, 32'h81, 32'h0000_1357, 32'h0, 1'b1, 1);
    issue("mis_st_wrap", 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0A0B_0C0D, 32'h0, 1'b1, 1);
`else
    for (int i = 2; i < 6; i++) exp_rd.push_back(i);
    issue("mis_ld_word", 1'b0, 2'b11, 1'b0, 32'h02, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    push_wr(32'h81, 8'h13); push_wr(32'h82, 8'h57);
    issue("mis_st_half", 1'b1, 2'b10, 1'b0, 32'h81, 32'h0000_1357, 32'h0, 1'b0, 3);
    push_wr(32'hFFFF_FFFE, 8'h0A); push_wr(32'hFFFF_FFFF, 8'h0B);
    push_wr(32'h0000_0000, 8'h0C); push_wr(32'h0000_0001, 8'h0D);
    issue("mis_st_wrap", 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0A0B_0C0D, 32'h0, 1'b0, 5);
`endif

    // Reset abort after two of four store bytes
    push_wr(32'h40, 8'hAA); push_wr(32'h41, 8'hBB);
    base = wr_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b11;
    req_unsigned_i = 1'b0; req_addr_i = 32'h40; req_wdata_i = 32'hAABB_CCDD;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    g = 0;
    while (wr_cnt < base + 2 && g < 10) begin
      @(posedge clk_i);
      #1 g++;
    end
    if (g >= 10) fail_now("abort_wr_timeout");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_ready_in_rst", {31'd0, req_ready_o}, 32'd1);
    chk("abort_we_in_rst", {31'd0, mem_we_o}, 32'd0);
    chk("abort_resp_in_rst", {31'd0, resp_valid_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_ready_after", {31'd0, req_ready_o}, 32'd1);
    repeat (6) @(negedge clk_i);
    chk("abort_mem40", {24'd0, wmem[8'h40]}, 32'h0000_00AA);
    chk("abort_mem41", {24'd0, wmem[8'h41]}, 32'h0000_00BB);
    chk("abort_mem42", {24'd0, wmem[8'h42]}, 32'h0);
    chk("abort_mem43", {24'd0, wmem[8'h43]}, 32'h0);

    // Still operational afterwards
    exp_rd.push_back(32'h30);
    issue("ld_after_abort", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFF_FFF0, 1'b0, 2);

    repeat (3) @(negedge clk_i);
    chk("mem10", {24'd0, wmem[8'h10]}, 32'h12);
    chk("mem13", {24'd0, wmem[8'h13]}, 32'h78);
    chk("left_resp", exp_resp.size(), 32'd0);
    chk("left_wr", exp_wr.size(), 32'd0);
    chk("left_rd", exp_rd.size(), 32'd0);
  endtask

  initial begin
    fork
      run_monitor();
      run_stim();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clk_i, input, 1, rising-edge clock.
REQ-002 SHALL have rst_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have req_valid_i, input, 1, CPU access request present.
REQ-004 SHALL have req_ready_o, output, 1, unit accepts a request this cycle.
REQ-005 SHALL have req_write_i, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have req_size_i, input, 2, size code: 2'b11 word, 2'b10 half, 2'b01 byte, 2'b00 illegal.
REQ-007 SHALL have req_unsigned_i, input, 1, zero-extend a load when 1, sign-extend when 0.
REQ-008 SHALL have req_addr_i, input, 32, byte address; req_wdata_i, input, 32, store data (right-justified).
REQ-009 SHALL have resp_valid_o, output, 1, one-cycle completion pulse; resp_rdata_o, output, 32, load result; resp_err_o, output, 1, access rejected.
REQ-010 SHALL have the byte-wide memory port: mem_addr_o (output, 32), mem_wdata_o (output, 8), mem_we_o (output, 1), mem_re_o (output, 1), mem_rdata_i (input, 8, combinational, valid in the same cycle as mem_addr_o).

Function
REQ-011 SHALL implement FSM states IDLE, XFER and RESP.
REQ-012 SHALL drive req_ready_o = 1 only in IDLE.
REQ-013 SHALL accept a request on a rising edge where req_valid_i && req_ready_o, latching addr, wdata, size, write and unsigned.
REQ-014 SHALL go from IDLE to XFER on acceptance with byte counter cnt = 0, where N = 4, 2 or 1 for word, half or byte.
REQ-015 SHALL go from IDLE directly to RESP with resp_err_o = 1 when size is illegal, with no memory strobe.
REQ-016 SHALL, in XFER, drive mem_addr_o = latched addr + cnt (32-bit wrap) and assert exactly one of mem_we_o or mem_re_o per cycle.
REQ-017 SHALL order bytes big-endian: byte k of N is wdata[8*(N-1-k)+7 : 8*(N-1-k)], so the MSB goes to the lowest address.
REQ-018 SHALL, for loads, shift each cycle: acc <= {acc[23:0], mem_rdata_i}.
REQ-019 SHALL go from XFER to RESP after cnt = N-1; total latency from accept edge to resp_valid_o is N+1 cycles.
REQ-020 SHALL assert resp_valid_o for exactly one cycle in RESP, then return to IDLE.
REQ-021 SHALL drive resp_rdata_o = acc extended to 32 bits per req_unsigned_i on loads, and 0 on stores or on error.
REQ-022 SHALL drive all memory strobes to 0, mem_addr_o to 0 and mem_wdata_o to 0 outside XFER.
REQ-023 SHALL ignore req_valid_i while not in IDLE; any change to request inputs mid-operation has no effect.

Reset
REQ-024 SHALL, while rst_i = 0, force state IDLE, cnt 0, acc 0 and all outputs 0 except req_ready_o.
REQ-025 SHALL drive req_ready_o = 1 in the first cycle after reset release.
REQ-026 SHALL treat reset during XFER as an abort: bytes already written stay written, and no response is issued.

Configuration
REQ-027 SHALL support the macro LSU_ALIGN_CHECK_EN.
REQ-028 SHALL, when LSU_ALIGN_CHECK_EN is defined, route a word request with addr[1:0] != 0, or a half request with addr[0] != 0, IDLE->RESP with resp_err_o = 1 and no memory strobe.
REQ-029 SHALL, when LSU_ALIGN_CHECK_EN is undefined, perform misaligned accesses byte-serially at consecutive addresses, with resp_err_o driven by illegal size only.

Structure
REQ-030 SHALL place the size codes (WORD/HALF/BYTE) and the FSM state encoding in package lsu_pkg.
REQ-031 SHALL implement extension in sub-module lsu_extend (inputs: acc, size, unsigned; output: 32-bit result).

Verification
REQ-032 Word store 0x12345678 @0x10 -> mem_we_o for 4 cycles; addresses 0x10..0x13 receive 0x12, 0x34, 0x56, 0x78; resp_valid_o on cycle 5 after accept.
REQ-033 Signed half load @0x20 where memory holds 0x80, 0x01 -> resp_rdata_o = 0xFFFF8001; with unsigned -> 0x00008001.
REQ-034 Unsigned byte load of 0xF0 -> 0x000000F0; signed -> 0xFFFFFFF0; resp_valid_o 2 cycles after accept.
REQ-035 Word load @0x02 with LSU_ALIGN_CHECK_EN defined -> resp_err_o = 1, no mem strobe, response on the next cycle; without the macro -> bytes are read from 0x02..0x05.
REQ-036 Illegal size 2'b00 -> immediate error response, no strobe.
REQ-037 Assert rst_i low after 2 of 4 store bytes -> only 2 bytes are written, no resp_valid_o, and req_ready_o = 1 after release.
